// File: rtl/ula_lo_seq.sv
// Sequential logic/shift unit: logic ops finish in one clock, shifts and rotates
// advance one bit per clock, with registered result, O/C/S/Z flags and START/BUSY/DONE.
module ula_lo_seq #(
    parameter int BITS = 8,
    parameter int SHW  = $clog2(BITS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [BITS-1:0] a,
    input  logic [BITS-1:0] b,
    input  logic [4:0]      op,
    input  logic [SHW-1:0]  shamt,
    output logic [BITS-1:0] resu,
    output logic            o,
    output logic            c,
    output logic            s,
    output logic            z,
    output logic            busy,
    output logic            done
);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t          state, state_next;
    logic [BITS-1:0] work, work_next;
    logic [SHW-1:0]  cnt, cnt_next;
    logic [1:0]      kind, kind_next;
    logic [BITS-1:0] resu_next;
    logic            o_next, c_next, s_next, z_next, done_next;

    logic [BITS:0]   stepped;
    logic [BITS-1:0] logic_res;

    // One 1-bit step of the selected shift; the MSB of the return is the bit shifted out.
    function automatic logic [BITS:0] shift_step(input logic [1:0] k, input logic [BITS-1:0] w);
        logic [BITS:0] r;
        case (k)
            2'b00:   r = {w[BITS-1], w[BITS-2:0], 1'b0};
            2'b01:   r = {w[0], w[BITS-1], w[BITS-1:1]};
            2'b10:   r = {w[0], 1'b0, w[BITS-1:1]};
            default: r = {w[BITS-1], w[BITS-2:0], w[BITS-1]};
        endcase
        return r;
    endfunction

    // The low four opcode bits select the minterms (A&B, ~A&B, A&~B, ~A&~B) to OR together;
    // 1111 is the exception and yields the constant 1 rather than all ones.
    function automatic logic [BITS-1:0] logic_op(input logic [3:0] f,
                                                 input logic [BITS-1:0] x,
                                                 input logic [BITS-1:0] y);
        logic [BITS-1:0] r;
        r = ({BITS{f[0]}} &  x &  y) |
            ({BITS{f[1]}} & ~x &  y) |
            ({BITS{f[2]}} &  x & ~y) |
            ({BITS{f[3]}} & ~x & ~y);
        if (f == 4'hF) r = {{(BITS-1){1'b0}}, 1'b1};
        return r;
    endfunction

    assign stepped   = shift_step(kind, work);
    assign logic_res = logic_op(op[3:0], a, b);
    assign busy      = (state == SHIFT);

    always_comb begin
        state_next = state;
        work_next  = work;
        cnt_next   = cnt;
        kind_next  = kind;
        resu_next  = resu;
        o_next     = o;
        c_next     = c;
        s_next     = s;
        z_next     = z;
        done_next  = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    if (op[4]) begin
                        resu_next = logic_res;
                        done_next = 1'b1;
                        if (op == 5'b10000) begin
                            z_next = 1'b1;
                            o_next = 1'b0;
                        end else if (op != 5'b10011 && op != 5'b11111) begin
                            z_next = (logic_res == '0);
                            s_next = logic_res[BITS-1];
                            o_next = 1'b0;
                        end
                    end else if (op[4:2] == 3'b010) begin
                        if (shamt == '0) begin
                            resu_next = a;
                            z_next    = (a == '0);
                            s_next    = a[BITS-1];
                            o_next    = 1'b0;
                            done_next = 1'b1;
                        end else begin
                            work_next  = a;
                            cnt_next   = shamt;
                            kind_next  = op[1:0];
                            state_next = SHIFT;
                        end
                    end else begin
                        done_next = 1'b1;
                    end
                end
            end
            SHIFT: begin
                work_next = stepped[BITS-1:0];
                cnt_next  = cnt - SHW'(1);
                if (cnt == SHW'(1)) begin
                    resu_next  = stepped[BITS-1:0];
                    c_next     = stepped[BITS];
                    z_next     = (stepped[BITS-1:0] == '0);
                    s_next     = stepped[BITS-1];
                    o_next     = 1'b0;
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Reset wins over everything, dropping any in-flight shift without a DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            work  <= '0;
            cnt   <= '0;
            kind  <= '0;
            resu  <= '0;
            o     <= 1'b0;
            c     <= 1'b0;
            s     <= 1'b0;
            z     <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            work  <= work_next;
            cnt   <= cnt_next;
            kind  <= kind_next;
            resu  <= resu_next;
            o     <= o_next;
            c     <= c_next;
            s     <= s_next;
            z     <= z_next;
            done  <= done_next;
        end
    end

endmodule

// File: doc/ula_lo_seq.md
Name: ula_lo_seq

Overview:
- Parametrised, sequential successor to the combinational logic ALU.
- Executes the 16 logic ops in one clock, and multi-bit shifts/rotates iteratively, one bit position per clock.
- Registered result and O/C/S/Z flags, with a START/BUSY/DONE handshake to the datapath controller.
- Sits in the execute stage beside the arithmetic unit; the controller muxes RESU and flags by opcode class.

Parameters:
- BITS, 8, operand/result width; power of two, >= 4.
- SHW, $clog2(BITS), width of the shift-amount port.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  synchronous, active-high reset.
- START  input  1  request; op accepted on an edge where START=1 and BUSY=0.
- A  input  BITS  operand A (signed); sampled only at acceptance.
- B  input  BITS  operand B (signed); sampled only at acceptance.
- OP  input  5  opcode; sampled only at acceptance.
- SHAMT  input  SHW  shift/rotate distance; sampled only at acceptance.
- RESU  output  BITS  registered result; held until the next completion.
- O  output  1  overflow flag.
- C  output  1  carry: last bit shifted or rotated out.
- S  output  1  sign flag: RESU[BITS-1].
- Z  output  1  zero flag: RESU==0.
- BUSY  output  1  high while a shift is in progress.
- DONE  output  1  one-cycle pulse; RESU and flags are valid and updated.

Behaviour:
- Reset: RST=1 at an edge forces state IDLE and sets RESU=0, O=C=S=Z=0, BUSY=0, DONE=0.
  - RST has priority over START and aborts any in-flight shift; no DONE is issued for the aborted op.
- States: IDLE, SHIFT.
  - IDLE with accepted START of a logic op, an illegal op, or a shift with SHAMT=0: result computed and registered at the accepting edge; DONE=1 for the following cycle; stay IDLE. Latency 1.
  - IDLE with accepted START of a shift with SHAMT=n>0: load working reg with A and counter with n; go SHIFT; BUSY=1.
  - SHIFT: each edge performs one 1-bit step and decrements the counter. At the edge where the counter reaches 0:
    - write RESU and flags;
    - go IDLE, BUSY=0;
    - DONE=1 for the next cycle.
  - Total shift latency is n+1 cycles from acceptance.
  - START while BUSY=1 is ignored (not queued).
  - START on the cycle DONE is high is accepted normally (back-to-back ops).
- Shift ops, one step each:
  - 01000 SLL: shift left, 0 in at LSB; C = old MSB.
  - 01001 SRA: shift right, sign replicated; C = old LSB.
  - 01010 SRL: shift right, 0 in at MSB; C = old LSB.
  - 01011 ROL: rotate left; C = old MSB.
  - With SHAMT=0, RESU=A and C is held.
- Logic ops, RESU computed from A and B:
  - 10000: 0
  - 10001: A&B
  - 10010: ~A&B
  - 10011: B
  - 10100: A&~B
  - 10101: A
  - 10110: A^B
  - 10111: A|B
  - 11000: ~A&~B
  - 11001: ~(A^B)
  - 11010: ~A
  - 11011: ~A|B
  - 11100: ~B
  - 11101: A|~B
  - 11110: ~A|~B
  - 11111: 1 (zero-extended)
- Flag update at completion:
  - Z = (RESU==0) and S = RESU[BITS-1] for all shift and logic ops, except as noted below.
  - OP 10000: Z=1; S held.
  - OP 10011 and 11111 (pass-through ops): Z, S, C, O all held.
  - C updated only by shifts with SHAMT>0; held otherwise.
  - O cleared to 0 by every completing op except the pass-through ops.
- Illegal opcode (any encoding not listed): DONE pulses after 1 cycle; RESU and all flags held.
- Operand/OP inputs may change freely after acceptance without affecting the in-flight op.

Test Plan:
- BITS=8. Reset, then check RESU=0x00, O/C/S/Z=0, BUSY=0, DONE=0. Assert RST while START=1 -> nothing accepted.
- SLL, A=0x96, SHAMT=3 -> BUSY high for 3 cycles; DONE 4 cycles after acceptance; RESU=0xB0, C=0, S=1, Z=0, O=0.
- SRA, A=0x81, SHAMT=1 -> DONE after 2 cycles; RESU=0xC0, C=1, S=1. Then ROL, A=0x81, SHAMT=1 -> RESU=0x03, C=1, S=0. Then SRL, A=0x01, SHAMT=1 -> RESU=0x00, C=1, Z=1.
- XOR 10110, A=0xF0, B=0xF0 -> DONE after 1 cycle; RESU=0x00, Z=1, S=0, C held. Then 10011 with B=0x80 -> RESU=0x80, Z stays 1, S stays 0. Then illegal OP 00000 -> DONE pulses; RESU stays 0x80.
- SLL, SHAMT=7; during BUSY, pulse START with an XOR op -> XOR ignored; shift result completes normally. START on the DONE cycle -> accepted.
- SLL, SHAMT=7; assert RST on the third SHIFT cycle -> next cycle BUSY=0, RESU=0, all flags 0, no DONE. A START on the following cycle is accepted and completes correctly.
